prienc_rr_arb: RTL and testbench
================================

PRIENC_RR_ARB -- requirements
Module: prienc_rr_arb

Interface
REQ-001 Parameter: N, default 8, number of request inputs (N >= 2).
REQ-002 Parameter: IDX_W, default $clog2(N), width of the encoded index output.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  N  request vector; bit k is request k.
REQ-006 Port: mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 Port: out_ready  input  1  consumer accepts the current result.
REQ-008 Port: valid  output  1  registered result present.
REQ-009 Port: idx  output  IDX_W  registered encoded index of the winning request.
REQ-010 Port: grant  output  N  registered one-hot of the winner; equals 1<<idx when valid, else 0.
REQ-011 Port: multi  output  1  registered flag: more than one req bit was set when the result was captured.

Function
REQ-012 The block SHALL be a two-state FSM: EMPTY (valid=0) and FULL (valid=1).
REQ-013 Load condition SHALL be (state==EMPTY) or (valid && out_ready).
REQ-014 On a load edge with |req==1: capture idx/grant/multi from the current req, go or stay FULL.
REQ-015 On a load edge with req==0: go EMPTY; idx, grant, multi SHALL be 0.
REQ-016 In FULL with out_ready=0: idx, grant, multi, valid SHALL hold; req changes ignored.
REQ-017 Latency: result SHALL appear on outputs exactly one cycle after the load edge; no combinational path from req to outputs.
REQ-018 Back-to-back: with out_ready=1 and req non-zero every cycle, one new result SHALL be produced per cycle.
REQ-019 mode=0: winner SHALL be the highest set index of req.
REQ-020 mode=1: internal pointer ptr (IDX_W bits) SHALL be highest priority; search order ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
REQ-021 ptr SHALL update only on a handshake (valid && out_ready) while mode=1: ptr <= (idx==0) ? N-1 : idx-1.
REQ-022 ptr SHALL hold while mode=0, so switching modes never corrupts rotation.
REQ-023 mode SHALL be sampled on the load edge; changing mode while FULL and stalled SHALL not alter the held result.
REQ-024 multi SHALL be 1 when popcount(req) >= 2 at capture, else 0.
REQ-025 Non-power-of-two N: ptr wrap SHALL use N-1; idx SHALL never exceed N-1.
REQ-026 Single-request case: winner SHALL be that bit in both modes regardless of ptr.

Reset
REQ-027 rst_n low SHALL immediately, without waiting for clk, force state=EMPTY, valid=0, idx=0, grant=0, multi=0, ptr=N-1.
REQ-028 Reset asserted mid-operation (FULL, stalled) SHALL discard the held result; no handshake or ptr update occurs.
REQ-029 After rst_n deasserts, the first load SHALL occur on the first rising edge with rst_n high.
REQ-030 After reset, mode=1 SHALL behave identically to mode=0 for the first grant, since ptr=N-1.

Verification (N=8)
REQ-031 mode=0, req=8'b0000_0101, out_ready=1 -> next cycle valid=1, idx=2, grant=8'b0000_0100, multi=1.
REQ-032 FULL with idx=2, out_ready=0, req changed to 8'h80 for 3 cycles -> idx stays 2; out_ready=1 -> next cycle idx=7, multi=0.
REQ-033 mode=1, req=8'hFF held, out_ready=1 -> idx sequence 7,6,5,4,3,2,1,0,7.
REQ-034 mode=1, req=8'b1000_0001 held, out_ready=1 -> idx alternates 7,0,7,0.
REQ-035 FULL and stalled, rst_n pulsed low between clock edges -> valid=0, idx=0, grant=0 immediately; after release, mode=1 with req=8'hFF -> first idx=7.
REQ-036 req=8'h00 for 5 cycles after reset -> valid stays 0, grant=0, multi=0.

Source files
------------

// File: rtl/prienc_rr_arb_if.sv
// Request/result bundle for prienc_rr_arb.
// The master side drives requests and ready; the slave side returns the registered result.
interface prienc_rr_arb_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
);
  logic [N-1:0]     req;
  logic             mode;
  logic             out_ready;
  logic             valid;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     grant;
  logic             multi;

  modport master (
    output req, mode, out_ready,
    input  valid, idx, grant, multi
  );

  modport slave (
    input  req, mode, out_ready,
    output valid, idx, grant, multi
  );
endinterface

// File: rtl/prienc_rr_arb.sv
// Priority encoder / round-robin arbiter with a one-entry registered result stage.
// mode=0 picks the highest set index; mode=1 searches downward from a rotating pointer.
module prienc_rr_arb #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input logic             clk,
  input logic             rst_n,
  prienc_rr_arb_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  localparam logic [IDX_W-1:0] PTR_TOP = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             multi_q, multi_d;

  logic             hs_c;
  logic             load_c;
  logic             any_c;
  logic             multi_c;
  logic [IDX_W-1:0] win_fix_c;
  logic [IDX_W-1:0] win_rr_c;
  logic             rr_found_c;
  logic [IDX_W-1:0] win_c;

  always_comb begin
    hs_c    = (state_q == FULL) && bus.out_ready;
    load_c  = (state_q == EMPTY) || hs_c;
    any_c   = |bus.req;
    multi_c = |(bus.req & (bus.req - N'(1)));
  end

  // Pointer advances past the winner being consumed, so the capture on the
  // same edge already sees the rotated priority.
  always_comb begin
    ptr_d = ptr_q;
    if (hs_c && bus.mode) begin
      ptr_d = (idx_q == '0) ? PTR_TOP : (idx_q - IDX_W'(1));
    end
  end

  always_comb begin
    win_fix_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (bus.req[IDX_W'(k)]) begin
        win_fix_c = IDX_W'(k);
      end
    end
  end

  // Search ptr, ptr-1, ..., 0, N-1, ..., ptr+1; modulo N keeps non-power-of-two N in range.
  always_comb begin
    int unsigned c;
    c          = 0;
    win_rr_c   = '0;
    rr_found_c = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      c = (32'(ptr_d) + N - k) % N;
      if (!rr_found_c && bus.req[IDX_W'(c)]) begin
        win_rr_c   = IDX_W'(c);
        rr_found_c = 1'b1;
      end
    end
  end

  always_comb begin
    win_c = bus.mode ? win_rr_c : win_fix_c;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    multi_d = multi_q;
    if (load_c) begin
      if (any_c) begin
        state_d = FULL;
        idx_d   = win_c;
        grant_d = N'(1) << win_c;
        multi_d = multi_c;
      end else begin
        state_d = EMPTY;
        idx_d   = '0;
        grant_d = '0;
        multi_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      grant_q <= '0;
      multi_q <= 1'b0;
      ptr_q   <= PTR_TOP;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.valid = (state_q == FULL);
  assign bus.idx   = idx_q;
  assign bus.grant = grant_q;
  assign bus.multi = multi_q;

endmodule

// File: tb/tb_prienc_rr_arb.sv
// Self-checking bench for prienc_rr_arb (N=8): directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_prienc_rr_arb;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = $clog2(N);

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_bad;

  prienc_rr_arb_if #(.N(N), .IDX_W(IDX_W)) bus ();

  prienc_rr_arb #(.N(N), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: fixed = highest set bit; round-robin = highest set bit at or
  // below ptr, otherwise highest set bit overall.
  function automatic int top_idx(input logic [N-1:0] r);
    for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    return 0;
  endfunction

  function automatic int rr_idx(input logic [N-1:0] r, input int p);
    for (int i = p; i >= 0; i--) if (r[i]) return i;
    return top_idx(r);
  endfunction

  function automatic int adv_ptr(input int p, input bit rotate, input int last);
    if (!rotate) return p;
    return (last == 0) ? N - 1 : last - 1;
  endfunction

  bit m_valid;
  int m_idx;
  bit m_multi;
  int m_ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_multi <= 1'b0;
      m_ptr   <= N - 1;
    end else begin
      m_ptr <= adv_ptr(m_ptr, m_valid && bus.out_ready && bus.mode, m_idx);
      if (!m_valid || bus.out_ready) begin
        if (bus.req == '0) begin
          m_valid <= 1'b0;
          m_idx   <= 0;
          m_multi <= 1'b0;
        end else begin
          m_valid <= 1'b1;
          m_idx   <= bus.mode ? rr_idx(bus.req, adv_ptr(m_ptr, m_valid && bus.out_ready && bus.mode, m_idx))
                              : top_idx(bus.req);
          m_multi <= ($countones(bus.req) > 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_valid", 32'(bus.valid), 32'(m_valid));
      chk("model_idx",   32'(bus.idx),   32'(m_idx));
      chk("model_grant", 32'(bus.grant), m_valid ? (32'd1 << m_idx) : 32'd0);
      chk("model_multi", 32'(bus.multi), 32'(m_multi));
    end
  end

  initial begin
    int seq_ff[9];
    int seq_81[4];
    int r;
    seq_ff = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    seq_81 = '{0, 7, 0, 7};
    n_cmp  = 0;
    n_bad  = 0;

    rst_n         = 1'b0;
    bus.req       = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_idx",   32'(bus.idx),   32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_multi", 32'(bus.multi), 32'd0);
    rst_n = 1'b1;

    // Idle requests keep the stage empty
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_valid", 32'(bus.valid), 32'd0);
      chk("idle_grant", 32'(bus.grant), 32'd0);
      chk("idle_multi", 32'(bus.multi), 32'd0);
    end

    bus.req = 8'b0000_0101;
    @(negedge clk);
    chk("fix_valid", 32'(bus.valid), 32'd1);
    chk("fix_idx",   32'(bus.idx),   32'd2);
    chk("fix_grant", 32'(bus.grant), 32'h04);
    chk("fix_multi", 32'(bus.multi), 32'd1);

    // Stall: req and mode changes must not disturb the held result
    bus.out_ready = 1'b0;
    bus.req       = 8'h80;
    for (int i = 0; i < 3; i++) begin
      bus.mode = (i == 1);
      @(negedge clk);
      chk("stall_idx",   32'(bus.idx),   32'd2);
      chk("stall_grant", 32'(bus.grant), 32'h04);
    end
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_idx",   32'(bus.idx),   32'd7);
    chk("release_multi", 32'(bus.multi), 32'd0);

    // Asynchronous reset while full and stalled
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("held_valid", 32'(bus.valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.valid), 32'd0);
    chk("arst_idx",   32'(bus.idx),   32'd0);
    chk("arst_grant", 32'(bus.grant), 32'd0);
    bus.mode      = 1'b1;
    bus.req       = 8'hFF;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("rr_ff_idx", 32'(bus.idx), 32'(seq_ff[i]));
    end

    bus.req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_81_idx", 32'(bus.idx), 32'(seq_81[i]));
    end

    // Single request wins regardless of pointer position
    bus.req = 8'h10;
    @(negedge clk);
    chk("single_idx",   32'(bus.idx),   32'd4);
    chk("single_multi", 32'(bus.multi), 32'd0);

    bus.req = 8'h00;
    @(negedge clk);
    chk("drain_valid", 32'(bus.valid), 32'd0);
    chk("drain_grant", 32'(bus.grant), 32'd0);

    bus.mode = 1'b0;
    bus.req  = 8'h0A;
    @(negedge clk);
    chk("fix2_idx",   32'(bus.idx),   32'd3);
    chk("fix2_multi", 32'(bus.multi), 32'd1);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0)      bus.req = '0;
      else if (r == 1) bus.req = N'(1) << $urandom_range(0, N - 1);
      else             bus.req = N'($urandom());
      bus.mode      = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
